serial_sub_ctrl: RTL

Bit-serial subtraction controller that computes `a - b - bin` over WIDTH-bit operands using one full-subtractor cell, one bit per clock. It sequences the cell (LSB first), keeps the borrow chain in a flip-flop between bits, and presents the result through a start/busy/done handshake. It is used where a parallel ripple subtractor costs too much area and a latency of WIDTH+1 cycles is acceptable.

---
 rtl/serial_sub_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial subtractor computing (a - b - bin) mod 2^WIDTH with one
// full-subtractor cell, LSB first, one bit per clock.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   start - request; accepted only in IDLE or DONE
//   a, b  - minuend / subtrahend, sampled on the accepting edge
//   bin   - initial borrow-in, sampled on the accepting edge
//   busy  - high while bits are being processed
//   done  - one-cycle pulse when d/bo have just updated
//   d     - registered difference
//   bo    - registered final borrow-out (a < b + bin)
module serial_sub_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bo
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] sd_q, sd_d;
   logic             brw_q, brw_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             bo_q, bo_d;

   // Full-subtractor cell on the current LSBs and the carried borrow.
   logic cell_x, cell_y, cell_z, cell_diff, cell_bor;

   always_comb begin
      cell_x    = sa_q[0];
      cell_y    = sb_q[0];
      cell_z    = brw_q;
      cell_diff = cell_x ^ cell_y ^ cell_z;
      cell_bor  = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & cell_z);
   end

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      sd_d    = sd_q;
      brw_d   = brw_q;
      cnt_d   = cnt_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      d_d     = d_q;
      bo_d    = bo_q;

      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               sd_d    = '0;
               brw_d   = bin;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = StShift;
            end else begin
               state_d = StIdle;
            end
         end
         StShift: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            // Difference bits enter at the MSB so the LSB ends up at bit 0.
            sd_d  = {cell_diff, sd_q[WIDTH-1:1]};
            brw_d = cell_bor;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               d_d     = sd_d;
               bo_d    = cell_bor;
               done_d  = 1'b1;
               state_d = StDone;
            end else begin
               busy_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         sa_q    <= '0;
         sb_q    <= '0;
         sd_q    <= '0;
         brw_q   <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         d_q     <= '0;
         bo_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         sd_q    <= sd_d;
         brw_q   <= brw_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         d_q     <= d_d;
         bo_q    <= bo_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign d    = d_q;
   assign bo   = bo_q;

endmodule
